alu_dispatch: RTL and testbench



---
 rtl/alu_dispatch.sv | 140 ++++++++++++++
 tb/tb_alu_dispatch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// Sequential front-end for the 8-bit sum/minus/multiply/division/compare cells.
// Latches one request, lets the cells settle for EXEC_CYCLES, then holds the captured result.
module alu_dispatch #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_zero,
    output logic        out_dz,
    output logic        out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [2:0]  op_reg;
    logic [7:0]  a_reg, b_reg;
    logic [15:0] result_reg;
    logic        zero_reg, dz_reg, err_reg;
    logic        accept, capture;

    // Combinational arithmetic cells, driven only from the latched request.
    logic [7:0]  sum8, diff8, div_q, div_r, safe_b;
    logic [15:0] prod16, cell_result;
    logic        cell_dz, cell_err, cell_zero;

    assign sum8   = a_reg + b_reg;
    assign diff8  = a_reg - b_reg;
    assign prod16 = 16'(a_reg) * 16'(b_reg);
    // Substitute divisor keeps the divider free of X when B is zero; its output is discarded then.
    assign safe_b = (b_reg == 8'd0) ? 8'd1 : b_reg;
    assign div_q  = a_reg / safe_b;
    assign div_r  = a_reg % safe_b;

    always_comb begin
        cell_result = 16'h0000;
        cell_dz     = 1'b0;
        cell_err    = 1'b0;
        case (op_reg)
            3'b000: cell_result = {8'h00, sum8};
            3'b001: cell_result = {8'h00, diff8};
            3'b010: cell_result = prod16;
            3'b011: begin
                if (b_reg == 8'd0) begin
                    cell_dz = 1'b1;
                end else begin
                    cell_result = {div_r, div_q};
                end
            end
            3'b100: cell_result = {15'b0, a_reg == b_reg};
            3'b101: cell_result = {15'b0, a_reg > b_reg};
            3'b110: cell_result = {15'b0, a_reg < b_reg};
            default: cell_err = 1'b1;
        endcase
    end

    assign cell_zero = (cell_result == 16'h0000);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    count_next = COUNT_LOAD;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (count_reg == 4'd0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= 4'd0;
            op_reg     <= 3'd0;
            a_reg      <= 8'd0;
            b_reg      <= 8'd0;
            result_reg <= 16'h0000;
            zero_reg   <= 1'b0;
            dz_reg     <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                op_reg <= in_op;
                a_reg  <= in_a;
                b_reg  <= in_b;
            end
            // Result and flags persist past DONE until the next capture.
            if (capture) begin
                result_reg <= cell_result;
                zero_reg   <= cell_zero;
                dz_reg     <= cell_dz;
                err_reg    <= cell_err;
            end
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign out_result = result_reg;
    assign out_zero   = zero_reg;
    assign out_dz     = dz_reg;
    assign out_err    = err_reg;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed testbench for alu_dispatch: opcode results, latency, backpressure and reset mid-operation.
module tb_alu_dispatch;

    localparam int EXEC = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_dz;
    logic        out_err;

    int tests;
    int fails;

    alu_dispatch #(.EXEC_CYCLES(EXEC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_zero  (out_zero),
        .out_dz    (out_dz),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, scramble inputs while busy, check latency/result/flags, release.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_res, input logic [2:0] exp_flags);
        int cycles;
        check({tag, "_in_ready"}, 16'(in_ready), 16'd1);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        tick();
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            in_valid = 1'($urandom_range(0, 1));
            in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
            tick();
            cycles++;
        end
        check({tag, "_latency"}, 16'(cycles), 16'(EXEC));
        check({tag, "_result"}, out_result, exp_res);
        check({tag, "_flags"}, 16'({out_zero, out_dz, out_err}), 16'(exp_flags));
        $display("[TB] %s op=%b a=%0d b=%0d -> result=%h zero=%b dz=%b err=%b", tag, op, a, b,
                 out_result, out_zero, out_dz, out_err);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release"}, 16'({in_ready, out_valid}), 16'b10);
        check({tag, "_held"}, out_result, exp_res);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_a = 8'd0; in_b = 8'd0;
        tick();
        check("reset_outputs", 16'({in_ready, out_valid, out_zero, out_dz, out_err}), 16'b10000);
        check("reset_result", out_result, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_ready", 16'(in_ready), 16'd1);

        // flags packed as {zero, dz, err}
        do_op("add_wrap",  3'b000, 8'd200, 8'd100, 16'h002C, 3'b000);
        do_op("sub_wrap",  3'b001, 8'd5,   8'd10,  16'h00FB, 3'b000);
        do_op("mul_max",   3'b010, 8'd255, 8'd255, 16'hFE01, 3'b000);
        do_op("mul_zero",  3'b010, 8'd7,   8'd0,   16'h0000, 3'b100);
        do_op("div",       3'b011, 8'd100, 8'd7,   16'h020E, 3'b000);
        do_op("div_zero",  3'b011, 8'd9,   8'd0,   16'h0000, 3'b110);
        do_op("gt",        3'b101, 8'd3,   8'd2,   16'h0001, 3'b000);
        do_op("lt",        3'b110, 8'd3,   8'd2,   16'h0000, 3'b100);
        do_op("eq",        3'b100, 8'd5,   8'd5,   16'h0001, 3'b000);
        do_op("illegal",   3'b111, 8'd4,   8'd4,   16'h0000, 3'b101);

        // Backpressure: result held while out_ready stays low.
        in_op = 3'b000; in_a = 8'd1; in_b = 8'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < EXEC; i++) tick();
        check("bp_enter_done", 16'(out_valid), 16'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'(i % 2); in_a = 8'($urandom); in_op = 3'($urandom);
            tick();
            check("bp_hold", 16'({out_valid, in_ready}), 16'b10);
            check("bp_result", out_result, 16'h0003);
            $display("[TB] bp cycle %0d valid=%b ready=%b result=%h", i, out_valid, in_ready, out_result);
        end
        // in_valid alongside out_ready in DONE: not accepted until the IDLE cycle.
        in_op = 3'b000; in_a = 8'd10; in_b = 8'd20; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_not_accepted_in_done", 16'({in_ready, out_valid}), 16'b10);
        tick();
        in_valid = 1'b0;
        check("bp_accepted_in_idle", 16'(in_ready), 16'd0);
        for (int i = 0; i < EXEC; i++) tick();
        check("bp_next_result", out_result, 16'h001E);
        check("bp_next_valid", 16'(out_valid), 16'd1);
        $display("[TB] bp follow-up result=%h", out_result);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset two cycles after accept discards the in-flight op.
        in_op = 3'b010; in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", 16'({in_ready, out_valid, out_zero, out_dz, out_err}), 16'b10000);
        check("rst_mid_result", out_result, 16'h0000);
        tick();
        rst = 1'b0;
        for (int i = 0; i < EXEC + 3; i++) begin
            tick();
            check("rst_no_valid", 16'({out_valid, in_ready}), 16'b01);
        end
        $display("[TB] reset mid-EXEC: out_valid stayed low");
        do_op("add_after_rst", 3'b000, 8'd1, 8'd1, 16'h0002, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
